// File: rtl/cpu_datamem_pkg.sv
// cpu_datamem_pkg: shared grant-source and completion-tag types for the data-memory arbiter
package cpu_datamem_pkg;
    typedef enum logic [1:0] {SRC_NONE, SRC_EX, SRC_CPU, SRC_ACCEL} grant_src_t;
    typedef struct packed {logic vld; logic we; logic [2:0] chan;} accel_tag_t;
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = 3'(i);
        return idx;
    endfunction
endpackage

// File: rtl/cpu_datamem_rr_arb.sv
// cpu_datamem_rr_arb: one-hot round-robin pick searching upward from ptr with wrap
module cpu_datamem_rr_arb #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] nxt_ptr
);
    int   idx;
    logic found;
    always_comb begin
        gnt     = '0;
        nxt_ptr = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nxt_ptr  = PW'((idx + 1) % N);
            end
        end
    end
endmodule

// File: rtl/cpu_datamem_arbiter.sv
// cpu_datamem_arbiter: single-port data-memory arbiter for ex, CPU and accelerator channels
module cpu_datamem_arbiter
    import cpu_datamem_pkg::*;
#(
    parameter int NUM_ACCEL  = 2,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LINE_W     = 512,
    parameter int MEM_RD_LAT = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           ex_addr,
    input  logic [DATA_W-1:0]           ex_wrt_data,
    input  logic                        ex_wrt_en,
    input  logic                        ex_rd_en,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [DATA_W-1:0]           cpu_wrt_data,
    input  logic                        cpu_wrt_en,
    input  logic                        cpu_rd_en,
    output logic                        cpu_stall,
    output logic [DATA_W-1:0]           cpu_rd_data,
    output logic [DATA_W-1:0]           ex_rd_data,
    input  logic [NUM_ACCEL-1:0]        accel_req_vld,
    input  logic [NUM_ACCEL-1:0]        accel_req_we,
    input  logic [NUM_ACCEL*ADDR_W-1:0] accel_addr,
    input  logic [NUM_ACCEL*DATA_W-1:0] accel_wrt_data,
    output logic [NUM_ACCEL-1:0]        accel_req_rdy,
    output logic [NUM_ACCEL-1:0]        accel_wrt_done,
    output logic [NUM_ACCEL-1:0]        accel_rd_valid,
    output logic [LINE_W-1:0]           accel_rd_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wrt_data,
    output logic                        mem_wrt_en,
    input  logic [LINE_W-1:0]           mem_rd_data
);
    localparam int PW = (NUM_ACCEL > 1) ? $clog2(NUM_ACCEL) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic                 ex_req, cpu_req, any_starved;
    logic [NUM_ACCEL-1:0] starved, gnt_s, gnt_v, accel_gnt;
    logic [PW-1:0]        rr_ptr, nxt_s, nxt_v;
    logic [SW-1:0]        starve_cnt [NUM_ACCEL];
    grant_src_t           src;
    logic [ADDR_W-1:0]    a_addr;
    logic [DATA_W-1:0]    a_data;
    logic                 a_we;
    accel_tag_t           tag_in, tag_out;
    accel_tag_t           tag_pipe [MEM_RD_LAT];

    assign ex_req      = ex_wrt_en | ex_rd_en;
    assign cpu_req     = cpu_wrt_en | cpu_rd_en;
    assign any_starved = |starved;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_ACCEL; i++)
            starved[i] = accel_req_vld[i] && (starve_cnt[i] >= SW'(STARVE_MAX));
    end

    // Both arbiters share one pointer so starved promotion keeps the same rotation order
    cpu_datamem_rr_arb #(.N(NUM_ACCEL), .PW(PW)) u_rr_starved (
        .req(starved), .ptr(rr_ptr), .gnt(gnt_s), .nxt_ptr(nxt_s)
    );
    cpu_datamem_rr_arb #(.N(NUM_ACCEL), .PW(PW)) u_rr_all (
        .req(accel_req_vld), .ptr(rr_ptr), .gnt(gnt_v), .nxt_ptr(nxt_v)
    );

    assign src = !rst_n         ? SRC_NONE  :
                 ex_req         ? SRC_EX    :
                 any_starved    ? SRC_ACCEL :
                 cpu_req        ? SRC_CPU   :
                 |accel_req_vld ? SRC_ACCEL : SRC_NONE;

    assign accel_gnt     = (src != SRC_ACCEL) ? '0 : any_starved ? gnt_s : gnt_v;
    assign accel_req_rdy = accel_gnt;

    always_comb begin
        a_addr = '0;
        a_data = '0;
        a_we   = 1'b0;
        for (int i = 0; i < NUM_ACCEL; i++)
            if (accel_gnt[i]) begin
                a_addr = accel_addr[i*ADDR_W +: ADDR_W];
                a_data = accel_wrt_data[i*DATA_W +: DATA_W];
                a_we   = accel_req_we[i];
            end
    end

    assign mem_addr     = (src == SRC_EX) ? ex_addr : (src == SRC_CPU) ? cpu_addr :
                          (src == SRC_ACCEL) ? a_addr : '0;
    assign mem_wrt_data = (src == SRC_EX) ? ex_wrt_data : (src == SRC_CPU) ? cpu_wrt_data :
                          (src == SRC_ACCEL) ? a_data : '0;
    assign mem_wrt_en   = (src == SRC_EX) ? ex_wrt_en : (src == SRC_CPU) ? cpu_wrt_en :
                          (src == SRC_ACCEL) ? a_we : 1'b0;

    assign cpu_stall     = rst_n && cpu_req && (src != SRC_CPU);
    assign cpu_rd_data   = rst_n ? mem_rd_data[DATA_W-1:0] : '0;
    assign ex_rd_data    = rst_n ? mem_rd_data[DATA_W-1:0] : '0;
    assign accel_rd_data = rst_n ? mem_rd_data : '0;

    assign tag_in  = '{vld: |accel_gnt, we: a_we, chan: onehot_idx(8'(accel_gnt))};
    assign tag_out = tag_pipe[MEM_RD_LAT-1];

    assign accel_wrt_done = (tag_out.vld && tag_out.we)  ? NUM_ACCEL'(1) << tag_out.chan : '0;
    assign accel_rd_valid = (tag_out.vld && !tag_out.we) ? NUM_ACCEL'(1) << tag_out.chan : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_ACCEL; i++) starve_cnt[i] <= '0;
            for (int k = 0; k < MEM_RD_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            if (|accel_gnt) rr_ptr <= any_starved ? nxt_s : nxt_v;
            for (int i = 0; i < NUM_ACCEL; i++)
                starve_cnt[i] <= (!accel_req_vld[i] || accel_gnt[i]) ? '0 :
                                 (starve_cnt[i] >= SW'(STARVE_MAX)) ? starve_cnt[i] :
                                 starve_cnt[i] + SW'(1);
            tag_pipe[0] <= tag_in;
            for (int k = 1; k < MEM_RD_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end
endmodule

// File: tb/tb_cpu_datamem_arbiter.sv
// tb_cpu_datamem_arbiter: directed bench with memory model and completion scoreboard
module tb_cpu_datamem_arbiter;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  ex_addr, cpu_addr;
    logic [31:0]  ex_wrt_data, cpu_wrt_data;
    logic         ex_wrt_en, ex_rd_en, cpu_wrt_en, cpu_rd_en;
    logic         cpu_stall;
    logic [31:0]  cpu_rd_data, ex_rd_data;
    logic [1:0]   accel_req_vld, accel_req_we, accel_req_rdy, accel_wrt_done, accel_rd_valid;
    logic [31:0]  accel_addr;
    logic [63:0]  accel_wrt_data;
    logic [511:0] accel_rd_data;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_wrt_data;
    logic         mem_wrt_en;
    logic [511:0] mem_rd_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int           due;
        int           chan;
        logic         we;
        logic [511:0] line;
    } exp_t;
    exp_t q[$];

    logic [31:0]  mem [256];
    logic [255:0] wr_vld = '0;
    logic [511:0] rd_pipe [LAT] = '{default: '0};

    cpu_datamem_arbiter #(
        .NUM_ACCEL(2), .ADDR_W(16), .DATA_W(32), .LINE_W(512),
        .MEM_RD_LAT(LAT), .STARVE_MAX(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_addr(ex_addr), .ex_wrt_data(ex_wrt_data), .ex_wrt_en(ex_wrt_en), .ex_rd_en(ex_rd_en),
        .cpu_addr(cpu_addr), .cpu_wrt_data(cpu_wrt_data), .cpu_wrt_en(cpu_wrt_en),
        .cpu_rd_en(cpu_rd_en), .cpu_stall(cpu_stall), .cpu_rd_data(cpu_rd_data),
        .ex_rd_data(ex_rd_data), .accel_req_vld(accel_req_vld), .accel_req_we(accel_req_we),
        .accel_addr(accel_addr), .accel_wrt_data(accel_wrt_data), .accel_req_rdy(accel_req_rdy),
        .accel_wrt_done(accel_wrt_done), .accel_rd_valid(accel_rd_valid),
        .accel_rd_data(accel_rd_data), .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data),
        .mem_wrt_en(mem_wrt_en), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word(input logic [15:0] a);
        return wr_vld[a[7:0]] ? mem[a[7:0]] : 32'h1000_0000 + 32'(a) * 3;
    endfunction

    function automatic logic [511:0] mk_line(input logic [15:0] a);
        return {{15{{16'hA5A5, a}}}, word(a)};
    endfunction

    always @(posedge clk) begin
        if (mem_wrt_en) begin
            mem[mem_addr[7:0]]    <= mem_wrt_data;
            wr_vld[mem_addr[7:0]] <= 1'b1;
        end
        rd_pipe[0] <= mk_line(mem_addr);
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rd_data = rd_pipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed_lo=%0h expected_lo=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic acc(input string tag, input logic [1:0] exp_rdy);
        chk(tag, 64'(accel_req_rdy), 64'(exp_rdy));
        for (int i = 0; i < 2; i++)
            if (exp_rdy[i])
                q.push_back('{due: cyc + LAT, chan: i, we: accel_req_we[i],
                              line: accel_req_we[i] ? 512'(0) : mk_line(accel_addr[i*16 +: 16])});
    endtask

    exp_t         m_e;
    logic [1:0]   m_rv, m_wd;
    logic [511:0] m_line;
    always @(negedge clk) begin
        #2;
        m_rv   = '0;
        m_wd   = '0;
        m_line = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            m_e = q.pop_front();
            if (m_e.we) m_wd[m_e.chan] = 1'b1;
            else begin
                m_rv[m_e.chan] = 1'b1;
                m_line         = m_e.line;
            end
        end
        if ((m_rv | m_wd | accel_rd_valid | accel_wrt_done) != 2'b00) begin
            chk($sformatf("sb_rd_valid_c%0d", cyc), 64'(accel_rd_valid), 64'(m_rv));
            chk($sformatf("sb_wrt_done_c%0d", cyc), 64'(accel_wrt_done), 64'(m_wd));
            if (m_rv != 2'b00) chk_line($sformatf("sb_line_c%0d", cyc), accel_rd_data, m_line);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    logic [511:0] lat_line;
    initial begin
        rst_n = 1'b0;
        ex_addr = 16'h0010; ex_wrt_data = 32'h1111_0000; ex_wrt_en = 1'b1; ex_rd_en = 1'b1;
        cpu_addr = 16'h0011; cpu_wrt_data = 32'h1234_5678; cpu_wrt_en = 1'b1; cpu_rd_en = 1'b1;
        accel_req_vld = 2'b11; accel_req_we = 2'b11;
        accel_addr = {16'h0030, 16'h0020};
        accel_wrt_data = {32'h0000_00B1, 32'hA0A0_0001};
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_wrt_en", 64'(mem_wrt_en), 0);
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_mem_wrt_data", 64'(mem_wrt_data), 0);
        chk("rst_cpu_stall", 64'(cpu_stall), 0);
        chk("rst_rdy", 64'(accel_req_rdy), 0);
        chk("rst_cpu_rd_data", 64'(cpu_rd_data), 0);
        chk("rst_ex_rd_data", 64'(ex_rd_data), 0);
        chk("rst_done_valid", 64'({accel_wrt_done, accel_rd_valid}), 0);
        chk("rst_accel_rd_data_nz", 64'(|accel_rd_data), 0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_wrt_en", 64'(mem_wrt_en), 1);
        chk("rel_addr", 64'(mem_addr), 64'h0010);
        chk("rel_data", 64'(mem_wrt_data), 64'h1111_0000);
        chk("rel_stall", 64'(cpu_stall), 1);
        acc("rel_rdy", 2'b00);

        @(negedge clk);
        ex_wrt_en = 1'b0; ex_rd_en = 1'b0; cpu_wrt_en = 1'b0; cpu_rd_en = 1'b0;
        accel_req_we = 2'b01;
        #1;
        acc("rr0_rdy", 2'b01);
        chk("rr0_wrt_en", 64'(mem_wrt_en), 1);
        chk("rr0_data", 64'(mem_wrt_data), 64'hA0A0_0001);
        @(negedge clk); #1;
        acc("rr1_rdy", 2'b10);
        chk("rr1_wrt_en", 64'(mem_wrt_en), 0);
        chk("rr1_addr", 64'(mem_addr), 64'h0030);
        @(negedge clk); #1;
        acc("rr2_rdy", 2'b01);
        @(negedge clk); #1;
        acc("rr3_rdy", 2'b10);

        @(negedge clk);
        accel_req_vld = 2'b00;
        #1;
        chk("idle_wrt_en", 64'(mem_wrt_en), 0);
        chk("idle_addr", 64'(mem_addr), 0);
        chk("idle_data", 64'(mem_wrt_data), 0);
        acc("idle_rdy", 2'b00);

        @(negedge clk);
        cpu_rd_en = 1'b1; cpu_addr = 16'h0060;
        accel_req_vld = 2'b01; accel_req_we = 2'b00; accel_addr = {16'h0030, 16'h0050};
        for (int c = 1; c <= 10; c++) begin
            #1;
            acc($sformatf("starve_rdy_c%0d", c), (c == 9) ? 2'b01 : 2'b00);
            chk($sformatf("starve_stall_c%0d", c), 64'(cpu_stall), (c == 9) ? 1 : 0);
            chk($sformatf("starve_addr_c%0d", c), 64'(mem_addr), (c == 9) ? 64'h0050 : 64'h0060);
            if (c == 4) chk("cpu_rd_data", 64'(cpu_rd_data), 64'(word(16'h0060)));
            @(negedge clk);
        end

        cpu_rd_en = 1'b0; accel_req_vld = 2'b00;
        ex_wrt_en = 1'b1; ex_addr = 16'h0010; ex_wrt_data = 32'hDEAD_BEEF;
        cpu_wrt_en = 1'b1; cpu_addr = 16'h0011; cpu_wrt_data = 32'h1234_5678;
        #1;
        chk("exw_wrt_en", 64'(mem_wrt_en), 1);
        chk("exw_addr", 64'(mem_addr), 64'h0010);
        chk("exw_data", 64'(mem_wrt_data), 64'hDEAD_BEEF);
        chk("exw_stall", 64'(cpu_stall), 1);
        @(negedge clk);
        ex_wrt_en = 1'b0;
        #1;
        chk("cpuw_addr", 64'(mem_addr), 64'h0011);
        chk("cpuw_data", 64'(mem_wrt_data), 64'h1234_5678);
        chk("cpuw_stall", 64'(cpu_stall), 0);
        @(negedge clk);
        cpu_wrt_en = 1'b0; ex_rd_en = 1'b1;
        #1;
        chk("exr_addr", 64'(mem_addr), 64'h0010);
        chk("exr_wrt_en", 64'(mem_wrt_en), 0);
        @(negedge clk);
        ex_rd_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("ex_rd_data", 64'(ex_rd_data), 64'hDEAD_BEEF);

        @(negedge clk);
        accel_req_vld = 2'b10; accel_req_we = 2'b00; accel_addr = {16'h0040, 16'h0050};
        #1;
        lat_line = mk_line(16'h0040);
        acc("lat_rdy", 2'b10);
        chk("lat_addr", 64'(mem_addr), 64'h0040);
        @(negedge clk);
        accel_req_vld = 2'b00;
        #1;
        chk("lat_rv1", 64'(accel_rd_valid), 0);
        @(negedge clk); #1;
        chk("lat_rv2", 64'(accel_rd_valid), 0);
        @(negedge clk); #1;
        chk("lat_rv3", 64'(accel_rd_valid), 64'b10);
        chk_line("lat_line", accel_rd_data, lat_line);

        @(negedge clk);
        accel_req_vld = 2'b01; accel_req_we = 2'b01; accel_addr = {16'h0040, 16'h0020};
        #1;
        acc("fl0_rdy", 2'b01);
        @(negedge clk);
        accel_req_vld = 2'b10; accel_req_we = 2'b00;
        #1;
        acc("fl1_rdy", 2'b10);
        @(negedge clk);
        accel_req_vld = 2'b00;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("flr_rdy", 64'(accel_req_rdy), 0);
        chk("flr_pulses", 64'({accel_wrt_done, accel_rd_valid}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("fl_post_rv_%0d", c), 64'(accel_rd_valid), 0);
            chk($sformatf("fl_post_wd_%0d", c), 64'(accel_wrt_done), 0);
            @(negedge clk);
        end
        #3;
        chk("sb_empty", 64'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
